// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard controller and its helpers.
//   - state_t : sequencer states (RUN, MEM_WAIT, HALT_DRAIN, HALTED)
//   - REG_AW  : register-file address width
//   - R0      : hard-wired zero register, never a real data dependency
package pipe_ctrl_pkg;

  localparam int REG_AW = 4;
  localparam logic [REG_AW-1:0] R0 = 4'h0;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_WAIT   = 2'd1,
    HALT_DRAIN = 2'd2,
    HALTED     = 2'd3
  } state_t;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect
// Purely combinational load-use detector. Flags the case where the
// instruction in EX is a load whose destination is read by the instruction
// in ID, so the consumer must wait one cycle for the loaded value.
// Ports:
//   i_src1_addr/i_src2_addr : ID-stage source register addresses
//   i_src1_used/i_src2_used : ID instruction actually reads that source
//   i_re_mem_EX             : EX instruction is a load
//   i_dst_addr_EX           : EX instruction destination register
//   o_load_use              : load-use hazard present this cycle
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] i_src1_addr,
  input  logic [REG_AW-1:0] i_src2_addr,
  input  logic              i_src1_used,
  input  logic              i_src2_used,
  input  logic              i_re_mem_EX,
  input  logic [REG_AW-1:0] i_dst_addr_EX,
  output logic              o_load_use
);

  logic w_src1_hit;
  logic w_src2_hit;

  assign w_src1_hit = i_src1_used & (i_src1_addr == i_dst_addr_EX);
  assign w_src2_hit = i_src2_used & (i_src2_addr == i_dst_addr_EX);

  // A load into R0 writes nothing, so it can never feed a consumer.
  assign o_load_use = i_re_mem_EX & (i_dst_addr_EX != R0) & (w_src1_hit | w_src2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. Priority, highest
// first: memory wait, taken branch, HLT, load-use.
// Ports:
//   clk, rst                      : clock, async active-high reset
//   i_src*_ID, i_re_mem_EX, ...   : hazard sources from ID/EX/MEM
//   i_mem_rdy                     : data memory finishes access this cycle
//   o_stall_*, o_flush_*          : pipeline flop hold / bubble controls
//   o_mem_req                     : data-memory access active
//   o_halted, o_mem_err           : sticky status flags
//   o_stall_cnt                   : saturating count of PC-stall cycles
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] i_src1_addr_ID,
  input  logic [REG_AW-1:0] i_src2_addr_ID,
  input  logic              i_src1_used_ID,
  input  logic              i_src2_used_ID,
  input  logic              i_re_mem_EX,
  input  logic [REG_AW-1:0] i_dst_addr_EX,
  input  logic              i_re_mem_MEM,
  input  logic              i_we_mem_MEM,
  input  logic              i_mem_rdy,
  input  logic              i_b_taken_MEM,
  input  logic              i_hlt_MEM,
  output logic              o_stall_PC,
  output logic              o_stall_IF_ID,
  output logic              o_stall_ID_EX,
  output logic              o_stall_EX_MEM,
  output logic              o_flush_IF_ID,
  output logic              o_flush_ID_EX,
  output logic              o_flush_EX_MEM,
  output logic              o_flush_MEM_WB,
  output logic              o_mem_req,
  output logic              o_halted,
  output logic              o_mem_err,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_halted;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_load_use;
  logic w_mem_req;
  logic w_mw;
  logic w_timeout;
  logic w_stall_pc, w_stall_if_id, w_stall_id_ex, w_stall_ex_mem;
  logic w_flush_if_id, w_flush_id_ex, w_flush_ex_mem, w_flush_mem_wb;

  hazard_detect u_hazard_detect (
    .i_src1_addr   (i_src1_addr_ID),
    .i_src2_addr   (i_src2_addr_ID),
    .i_src1_used   (i_src1_used_ID),
    .i_src2_used   (i_src2_used_ID),
    .i_re_mem_EX   (i_re_mem_EX),
    .i_dst_addr_EX (i_dst_addr_EX),
    .o_load_use    (w_load_use)
  );

  assign w_mem_req = ((r_state == RUN) || (r_state == MEM_WAIT)) & (i_re_mem_MEM | i_we_mem_MEM);
  assign w_mw      = w_mem_req & ~i_mem_rdy;
  // The last permitted wait cycle still without a ready ends the access as an error.
  assign w_timeout = (r_state == MEM_WAIT) & w_mw & (r_wait_cnt == WAIT_LAST);

  // Next-state and control decode; every branch starts from "no stall, no flush".
  always_comb begin
    w_next_state   = r_state;
    w_stall_pc     = 1'b0;
    w_stall_if_id  = 1'b0;
    w_stall_id_ex  = 1'b0;
    w_stall_ex_mem = 1'b0;
    w_flush_if_id  = 1'b0;
    w_flush_id_ex  = 1'b0;
    w_flush_ex_mem = 1'b0;
    w_flush_mem_wb = 1'b0;
    case (r_state)
      RUN: begin
        if (w_mw) begin
          w_stall_pc     = 1'b1;
          w_stall_if_id  = 1'b1;
          w_stall_id_ex  = 1'b1;
          w_stall_ex_mem = 1'b1;
          w_flush_mem_wb = 1'b1;
          w_next_state   = MEM_WAIT;
        end else if (i_b_taken_MEM) begin
          // PC loads the branch target, so no PC stall here.
          w_flush_if_id  = 1'b1;
          w_flush_id_ex  = 1'b1;
          w_flush_ex_mem = 1'b1;
        end else if (i_hlt_MEM) begin
          w_stall_pc     = 1'b1;
          w_flush_if_id  = 1'b1;
          w_flush_id_ex  = 1'b1;
          w_flush_ex_mem = 1'b1;
          w_next_state   = HALT_DRAIN;
        end else if (w_load_use) begin
          w_stall_pc     = 1'b1;
          w_stall_if_id  = 1'b1;
          w_flush_id_ex  = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (w_mw) begin
          w_stall_pc     = 1'b1;
          w_stall_if_id  = 1'b1;
          w_stall_id_ex  = 1'b1;
          w_stall_ex_mem = 1'b1;
          w_flush_mem_wb = 1'b1;
          if (w_timeout) begin
            w_next_state = HALTED;
          end
        end else begin
          // Access completes: this cycle lets the whole pipeline advance.
          w_next_state = RUN;
        end
      end
      HALT_DRAIN: begin
        w_stall_pc    = 1'b1;
        w_flush_if_id = 1'b1;
        w_next_state  = HALTED;
      end
      HALTED: begin
        w_stall_pc     = 1'b1;
        w_stall_if_id  = 1'b1;
        w_stall_id_ex  = 1'b1;
        w_stall_ex_mem = 1'b1;
      end
      default: begin
        w_next_state = RUN;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Wait counter only runs while an access stays in MEM_WAIT; every other path restarts it at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if ((r_state == MEM_WAIT) && (w_next_state == MEM_WAIT)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Sticky status flags: any entry into HALTED marks the core halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halted  <= 1'b0;
      r_mem_err <= 1'b0;
    end else begin
      if (w_next_state == HALTED) begin
        r_halted <= 1'b1;
      end
      if (w_timeout) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  // Saturating stall-cycle counter; the permanent stall of HALTED is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall_pc && (r_state != HALTED) && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Controls are forced inactive for as long as reset is asserted.
  assign o_stall_PC     = w_stall_pc     & ~rst;
  assign o_stall_IF_ID  = w_stall_if_id  & ~rst;
  assign o_stall_ID_EX  = w_stall_id_ex  & ~rst;
  assign o_stall_EX_MEM = w_stall_ex_mem & ~rst;
  assign o_flush_IF_ID  = w_flush_if_id  & ~rst;
  assign o_flush_ID_EX  = w_flush_id_ex  & ~rst;
  assign o_flush_EX_MEM = w_flush_ex_mem & ~rst;
  assign o_flush_MEM_WB = w_flush_mem_wb & ~rst;
  assign o_mem_req      = w_mem_req      & ~rst;
  assign o_halted       = r_halted;
  assign o_mem_err      = r_mem_err;
  assign o_stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// Scenario-by-scenario bench for pipe_hazard_ctrl. Each scenario builds a
// table of per-cycle inputs and expected control words; expectations are
// queued when inputs are driven and popped when the outputs are sampled on
// the falling edge. Small timeout and counter widths make the timeout and
// saturation corners reachable in a few cycles.
module tb_pipe_hazard_ctrl;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_CNT_W   = 4;

  // Control word: {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
  //                flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
  //                mem_req, halted, mem_err}
  localparam logic [10:0] C_IDLE   = 11'b0000_0000_000;
  localparam logic [10:0] C_LU     = 11'b1100_0100_000;
  localparam logic [10:0] C_MW     = 11'b1111_0001_100;
  localparam logic [10:0] C_MREQ   = 11'b0000_0000_100;
  localparam logic [10:0] C_BR     = 11'b0000_1110_000;
  localparam logic [10:0] C_HENTRY = 11'b1000_1110_000;
  localparam logic [10:0] C_DRAIN  = 11'b1000_1000_000;
  localparam logic [10:0] C_HALTED = 11'b1111_0000_010;
  localparam logic [10:0] C_ERR    = 11'b1111_0000_011;

  typedef struct packed {
    logic [3:0] s1;
    logic [3:0] s2;
    logic       u1;
    logic       u2;
    logic       re_ex;
    logic [3:0] dst;
    logic       re_m;
    logic       we_m;
    logic       rdy;
    logic       bt;
    logic       hlt;
  } stim_t;

  typedef struct packed {
    logic [10:0]         ctl;
    logic [TB_CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] src1_addr_ID, src2_addr_ID, dst_addr_EX;
  logic src1_used_ID, src2_used_ID, re_mem_EX, re_mem_MEM, we_mem_MEM;
  logic mem_rdy, b_taken_MEM, hlt_MEM;
  logic stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM;
  logic flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB;
  logic mem_req, halted, mem_err;
  logic [TB_CNT_W-1:0] stall_cnt;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [TB_CNT_W-1:0] exp_cnt = '0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_src1_addr_ID (src1_addr_ID),
    .i_src2_addr_ID (src2_addr_ID),
    .i_src1_used_ID (src1_used_ID),
    .i_src2_used_ID (src2_used_ID),
    .i_re_mem_EX    (re_mem_EX),
    .i_dst_addr_EX  (dst_addr_EX),
    .i_re_mem_MEM   (re_mem_MEM),
    .i_we_mem_MEM   (we_mem_MEM),
    .i_mem_rdy      (mem_rdy),
    .i_b_taken_MEM  (b_taken_MEM),
    .i_hlt_MEM      (hlt_MEM),
    .o_stall_PC     (stall_PC),
    .o_stall_IF_ID  (stall_IF_ID),
    .o_stall_ID_EX  (stall_ID_EX),
    .o_stall_EX_MEM (stall_EX_MEM),
    .o_flush_IF_ID  (flush_IF_ID),
    .o_flush_ID_EX  (flush_ID_EX),
    .o_flush_EX_MEM (flush_EX_MEM),
    .o_flush_MEM_WB (flush_MEM_WB),
    .o_mem_req      (mem_req),
    .o_halted       (halted),
    .o_mem_err      (mem_err),
    .o_stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input logic [3:0] s1, input logic [3:0] s2,
                               input logic u1, input logic u2, input logic re_ex,
                               input logic [3:0] dst, input logic re_m, input logic we_m,
                               input logic rdy, input logic bt, input logic hlt);
    stim_t s;
    s = {s1, s2, u1, u2, re_ex, dst, re_m, we_m, rdy, bt, hlt};
    return s;
  endfunction

  function automatic logic [10:0] obs_ctl();
    return {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
            flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
            mem_req, halted, mem_err};
  endfunction

  // Drives one cycle of inputs, queues the expectation, advances to the sampling point.
  // The expected counter follows the stall-cycle rule: +1 per PC-stall cycle outside HALTED, saturating.
  task automatic applyStimulus(input stim_t s, input logic [10:0] ctl);
    src1_addr_ID = s.s1;
    src2_addr_ID = s.s2;
    src1_used_ID = s.u1;
    src2_used_ID = s.u2;
    re_mem_EX    = s.re_ex;
    dst_addr_EX  = s.dst;
    re_mem_MEM   = s.re_m;
    we_mem_MEM   = s.we_m;
    mem_rdy      = s.rdy;
    b_taken_MEM  = s.bt;
    hlt_MEM      = s.hlt;
    sb.push_back({ctl, exp_cnt});
    if (ctl[10] && !ctl[1] && (exp_cnt != {TB_CNT_W{1'b1}})) exp_cnt = exp_cnt + 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      rst = (i < 2);
      if (i < 2) applyStimulus(mk(4'd3, 4'd3, 1, 1, 1, 4'd3, 1, 1, 0, 1, 1), C_IDLE);
      else       applyStimulus(mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0), C_IDLE);
      e = sb.pop_front();
      n_checks++;
      if (obs_ctl() !== e.ctl) begin
        n_fail++;
        $display("[TB] FAIL reset[%0d] ctl: got %b expected %b", i, obs_ctl(), e.ctl);
      end
      n_checks++;
      if (stall_cnt !== e.cnt) begin
        n_fail++;
        $display("[TB] FAIL reset[%0d] stall_cnt: got %0d expected %0d", i, stall_cnt, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_between();
    exp_t e;
    rst = 1'b1;
    exp_cnt = '0;
    applyStimulus(mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0), C_IDLE);
    e = sb.pop_front();
    n_checks++;
    if ({obs_ctl(), stall_cnt} !== {e.ctl, e.cnt}) begin
      n_fail++;
      $display("[TB] FAIL reset_between: got %b/%0d expected %b/%0d", obs_ctl(), stall_cnt, e.ctl, e.cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    stim_t tin[$];
    logic [10:0] tex[$];
    exp_t e;
    tin.push_back(mk(4'd3, 4'd7, 1, 1, 1, 4'd3, 0, 0, 0, 0, 0)); tex.push_back(C_LU);
    tin.push_back(mk(4'd3, 4'd7, 1, 1, 0, 4'd0, 0, 0, 0, 0, 0)); tex.push_back(C_IDLE);
    tin.push_back(mk(4'd1, 4'd5, 1, 1, 1, 4'd5, 0, 0, 0, 0, 0)); tex.push_back(C_LU);
    tin.push_back(mk(4'd5, 4'd5, 0, 0, 1, 4'd5, 0, 0, 0, 0, 0)); tex.push_back(C_IDLE);
    tin.push_back(mk(4'd0, 4'd0, 1, 1, 1, 4'd0, 0, 0, 0, 0, 0)); tex.push_back(C_IDLE);
    tin.push_back(mk(4'd4, 4'd2, 1, 1, 1, 4'd6, 0, 0, 0, 0, 0)); tex.push_back(C_IDLE);
    foreach (tin[i]) begin
      applyStimulus(tin[i], tex[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs_ctl() !== e.ctl) begin
        n_fail++;
        $display("[TB] FAIL load_use[%0d] ctl: got %b expected %b", i, obs_ctl(), e.ctl);
      end
      n_checks++;
      if (stall_cnt !== e.cnt) begin
        n_fail++;
        $display("[TB] FAIL load_use[%0d] stall_cnt: got %0d expected %0d", i, stall_cnt, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait();
    stim_t tin[$];
    logic [10:0] tex[$];
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      tin.push_back(mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 1, 0, 0, 0, 0)); tex.push_back(C_MW);
    end
    tin.push_back(mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 1, 0, 1, 0, 0)); tex.push_back(C_MREQ);
    tin.push_back(mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0)); tex.push_back(C_IDLE);
    tin.push_back(mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 1, 0, 0)); tex.push_back(C_MREQ);
    tin.push_back(mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1, 0, 0)); tex.push_back(C_IDLE);
    foreach (tin[i]) begin
      applyStimulus(tin[i], tex[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs_ctl() !== e.ctl) begin
        n_fail++;
        $display("[TB] FAIL mem_wait[%0d] ctl: got %b expected %b", i, obs_ctl(), e.ctl);
      end
      n_checks++;
      if (stall_cnt !== e.cnt) begin
        n_fail++;
        $display("[TB] FAIL mem_wait[%0d] stall_cnt: got %0d expected %0d", i, stall_cnt, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_load_use();
    stim_t tin[$];
    logic [10:0] tex[$];
    exp_t e;
    tin.push_back(mk(4'd3, 4'd7, 1, 1, 1, 4'd3, 0, 0, 0, 1, 0)); tex.push_back(C_BR);
    tin.push_back(mk(4'd3, 4'd7, 1, 1, 0, 4'd0, 0, 0, 0, 0, 0)); tex.push_back(C_IDLE);
    tin.push_back(mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1, 1, 0)); tex.push_back(C_BR);
    tin.push_back(mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 1, 0, 0, 1, 0)); tex.push_back(C_MW);
    tin.push_back(mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 1, 0, 1, 0, 0)); tex.push_back(C_MREQ);
    tin.push_back(mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0)); tex.push_back(C_IDLE);
    foreach (tin[i]) begin
      applyStimulus(tin[i], tex[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs_ctl() !== e.ctl) begin
        n_fail++;
        $display("[TB] FAIL branch[%0d] ctl: got %b expected %b", i, obs_ctl(), e.ctl);
      end
      n_checks++;
      if (stall_cnt !== e.cnt) begin
        n_fail++;
        $display("[TB] FAIL branch[%0d] stall_cnt: got %0d expected %0d", i, stall_cnt, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    stim_t tin[$];
    logic [10:0] tex[$];
    exp_t e;
    tin.push_back(mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 1)); tex.push_back(C_HENTRY);
    tin.push_back(mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0)); tex.push_back(C_DRAIN);
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) tin.push_back(mk(4'd3, 4'd3, 1, 1, 1, 4'd3, 1, 1, 0, 1, 1));
      else            tin.push_back(mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1, 0, 0));
      tex.push_back(C_HALTED);
    end
    foreach (tin[i]) begin
      applyStimulus(tin[i], tex[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs_ctl() !== e.ctl) begin
        n_fail++;
        $display("[TB] FAIL halt[%0d] ctl: got %b expected %b", i, obs_ctl(), e.ctl);
      end
      n_checks++;
      if (stall_cnt !== e.cnt) begin
        n_fail++;
        $display("[TB] FAIL halt[%0d] stall_cnt: got %0d expected %0d", i, stall_cnt, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    stim_t tin[$];
    logic [10:0] tex[$];
    exp_t e;
    // One RUN cycle plus TB_TIMEOUT wait cycles before the error lands.
    for (int k = 0; k < TB_TIMEOUT + 1; k++) begin
      tin.push_back(mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0, 0, 0)); tex.push_back(C_MW);
    end
    for (int k = 0; k < 3; k++) begin
      tin.push_back(mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 1, 0, 0)); tex.push_back(C_ERR);
    end
    foreach (tin[i]) begin
      applyStimulus(tin[i], tex[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs_ctl() !== e.ctl) begin
        n_fail++;
        $display("[TB] FAIL timeout[%0d] ctl: got %b expected %b", i, obs_ctl(), e.ctl);
      end
      n_checks++;
      if (stall_cnt !== e.cnt) begin
        n_fail++;
        $display("[TB] FAIL timeout[%0d] stall_cnt: got %0d expected %0d", i, stall_cnt, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0, 0, 0), C_MW);
      e = sb.pop_front();
      n_checks++;
      if ({obs_ctl(), stall_cnt} !== {e.ctl, e.cnt}) begin
        n_fail++;
        $display("[TB] FAIL reset_mid_wait[%0d]: got %b/%0d expected %b/%0d", i, obs_ctl(), stall_cnt, e.ctl, e.cnt);
      end
      @(posedge clk); #1;
    end
    // Assert reset between clock edges with the stalled access still presented.
    #2;
    rst = 1'b1;
    exp_cnt = '0;
    sb.push_back({C_IDLE, exp_cnt});
    #1;
    e = sb.pop_front();
    n_checks++;
    if ({obs_ctl(), stall_cnt} !== {e.ctl, e.cnt}) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_async: got %b/%0d expected %b/%0d", obs_ctl(), stall_cnt, e.ctl, e.cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    stim_t tin[$];
    logic [10:0] tex[$];
    exp_t e;
    for (int k = 0; k < 18; k++) begin
      tin.push_back(mk(4'd2, 4'd9, 1, 0, 1, 4'd2, 0, 0, 0, 0, 0)); tex.push_back(C_LU);
    end
    tin.push_back(mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0)); tex.push_back(C_IDLE);
    foreach (tin[i]) begin
      applyStimulus(tin[i], tex[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs_ctl() !== e.ctl) begin
        n_fail++;
        $display("[TB] FAIL saturation[%0d] ctl: got %b expected %b", i, obs_ctl(), e.ctl);
      end
      n_checks++;
      if (stall_cnt !== e.cnt) begin
        n_fail++;
        $display("[TB] FAIL saturation[%0d] stall_cnt: got %0d expected %0d", i, stall_cnt, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_mem_wait();
    test_branch_load_use();
    test_halt();
    reset_between();
    test_timeout();
    reset_between();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB). It drives the stall and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline flops. It resolves four conditions:
- load-use hazards;
- multi-cycle data-memory accesses, via a ready handshake;
- taken branches resolved in MEM;
- HLT draining.

It also keeps a saturating stall-cycle counter and a memory-timeout error flag.

Parameters:
MEM_TIMEOUT, 64, maximum number of MEM_WAIT cycles before a memory error is declared (must be ≥2).
CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
src1_addr_ID  in  4  ID-stage source register 1.
src2_addr_ID  in  4  ID-stage source register 2.
src1_used_ID  in  1  ID instruction reads src1.
src2_used_ID  in  1  ID instruction reads src2.
re_mem_EX  in  1  EX instruction is a load.
dst_addr_EX  in  4  EX instruction destination register.
re_mem_MEM  in  1  MEM instruction reads data memory.
we_mem_MEM  in  1  MEM instruction writes data memory.
mem_rdy  in  1  data memory completes the current access this cycle.
b_taken_MEM  in  1  branch in MEM is taken.
hlt_MEM  in  1  HLT instruction is in MEM.
stall_PC  out  1  hold PC.
stall_IF_ID  out  1  hold IF/ID flop.
stall_ID_EX  out  1  hold ID/EX flop.
stall_EX_MEM  out  1  hold EX/MEM flop.
flush_IF_ID  out  1  load a bubble into IF/ID.
flush_ID_EX  out  1  load a bubble into ID/EX.
flush_EX_MEM  out  1  load a bubble into EX/MEM.
flush_MEM_WB  out  1  load a bubble into MEM/WB.
mem_req  out  1  data-memory access is active.
halted  out  1  processor halted (sticky).
mem_err  out  1  memory timeout (sticky).
stall_cnt  out  CNT_W  cycles with stall_PC=1, excluding the HALTED state.

Behaviour:
- State machine states: RUN, MEM_WAIT, HALT_DRAIN, HALTED. Reset state is RUN.
- Reset values: halted=0, mem_err=0, stall_cnt=0, internal wait_cnt=0.
- While rst=1, every stall_*, flush_* and mem_req output is 0.
- mem_req = (re_mem_MEM | we_mem_MEM) in RUN or MEM_WAIT; otherwise 0.

Memory-wait condition (mw) = mem_req & ~mem_rdy. This has the highest priority.
- Outputs: stall_PC, stall_IF_ID, stall_ID_EX and stall_EX_MEM are all 1; flush_MEM_WB=1; all other flushes are 0.
- RUN→MEM_WAIT on mw, with wait_cnt cleared to 0.
- In MEM_WAIT, wait_cnt increments each cycle.
- MEM_WAIT→RUN in the first cycle with mem_rdy=1. That cycle drives no stall, so the pipeline advances and wait_cnt clears.
- If wait_cnt reaches MEM_TIMEOUT-1 with mem_rdy=0: set mem_err=1 and halted=1, then go to HALTED.
- A zero-wait access (mem_rdy=1 in the first cycle) causes no stall.

Branch, in RUN, when not mw:
- If b_taken_MEM=1, then flush_IF_ID, flush_ID_EX and flush_EX_MEM are 1.
- No stall is driven; the PC loads the target.
- The branch overrides load-use in the same cycle.

Load-use, in RUN, when there is no mw and no branch:
- The hazard is: re_mem_EX & dst_addr_EX≠0 & ((src1_used_ID & src1_addr_ID==dst_addr_EX) | (src2_used_ID & src2_addr_ID==dst_addr_EX)).
- Outputs: stall_PC=1, stall_IF_ID=1, flush_ID_EX=1. This gives exactly one bubble.
- R0 never causes a hazard.

Halt:
- In RUN, with no mw and no branch, hlt_MEM=1 moves the state to HALT_DRAIN.
- In that same cycle: stall_PC=1 and flush_IF_ID, flush_ID_EX and flush_EX_MEM are all 1, squashing younger instructions.
- HALT_DRAIN lasts exactly 1 cycle, with stall_PC=1 and flush_IF_ID=1. HLT is in WB during this cycle.
- HALT_DRAIN→HALTED with halted=1.
- In HALTED, all stall_* outputs are 1 and all flush_* outputs are 0. The state is held until rst.

Stall-cycle counter:
- stall_cnt increments on every clk edge where stall_PC=1 and the state is not HALTED.
- It saturates at all-ones.

Reset mid-operation:
- Any state returns asynchronously to RUN.
- The counters and sticky flags clear.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state encoding (2-bit: RUN=0, MEM_WAIT=1, HALT_DRAIN=2, HALTED=3);
  - the register-address width (4);
  - the constant R0 = 4'h0.
- One sub-module, hazard_detect, holds the purely combinational load-use compare.
- The FSM, priority mux and counters stay at top level.

Test Plan:
1. Load-use: LW R3 in EX and ADD reading R3 in ID → one cycle with stall_PC=1, stall_IF_ID=1 and flush_ID_EX=1; next cycle all 0. Repeating with dst=R0 → no stall.
2. Memory wait: re_mem_MEM=1 with mem_rdy low for 3 cycles and high on the 4th → 3 cycles with stall_PC..stall_EX_MEM=1 and flush_MEM_WB=1, no stall on the 4th, stall_cnt=3.
3. Branch and load-use together: b_taken_MEM=1 while the load-use hazard is present → flush_IF_ID, flush_ID_EX and flush_EX_MEM=1, stall_PC=0, stall_cnt unchanged.
4. Halt: hlt_MEM=1 → entry cycle with flushes and stall_PC; 1 HALT_DRAIN cycle; then halted=1 with all stalls=1, held for 10+ cycles; stall_cnt frozen.
5. Timeout, with MEM_TIMEOUT=4: we_mem_MEM=1 and mem_rdy held low → mem_err=1 and halted=1 after the 4th wait cycle; sticky.
6. Reset mid-operation: rst pulsed during MEM_WAIT, asynchronously off-edge → outputs 0 immediately, state RUN, stall_cnt=0; normal operation resumes after release.
